// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART block.
package uart_pkg;

  localparam int unsigned TxWidth = 8;
  localparam int unsigned TxDepth = 16;

  // TX scheduler states.
  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StPresent,
    StFlush
  } tx_sched_state_t;

endpackage

// File: rtl/uart_tx_sched.sv
// TX scheduler: drains the TX FIFO one word at a time and hands each word to
// the serialiser over a valid/ready handshake, with CTS gating, flush and
// threshold/done interrupts.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = TxWidth,
  parameter int unsigned DEPTH = TxDepth,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              cts_en_i,
  input  logic              cts_n_i,
  input  logic              flush_i,
  input  logic [ADDR_W:0]   thresh_i,
  output logic              fifo_ren_o,
  input  logic [WIDTH-1:0]  fifo_rdata_i,
  input  logic              fifo_valid_i,
  input  logic              fifo_empty_i,
  input  logic [ADDR_W:0]   fifo_lvl_i,
  output logic [WIDTH-1:0]  tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic              tx_busy_i,
  output logic              irq_thresh_o,
  output logic              irq_done_o,
  output logic              busy_o
);

  tx_sched_state_t state_q, state_d;
  logic [WIDTH-1:0] hold_q;
  logic             sent_pend_q, sent_pend_d;
  logic             ren_q;
  logic             irq_thresh_q;
  logic             irq_done_q;

  logic cts_ok;
  logic go;
  logic hold_load;
  logic handshake;
  logic done_cond;

  assign cts_ok    = !cts_en_i || !cts_n_i;
  assign go        = en_i && !fifo_empty_i && cts_ok && !flush_i;
  assign handshake = (state_q == StPresent) && tx_ready_i;
  assign hold_load = (state_q == StWait) && fifo_valid_i && !flush_i;
  assign done_cond = sent_pend_q && (state_q == StIdle) && fifo_empty_i && !tx_busy_i;

  // Next-state logic; flush preempts every state that holds or fetches a word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StFlush;
        end else if (go) begin
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = flush_i ? StFlush : StWait;
      end
      StWait: begin
        if (flush_i) begin
          state_d = StFlush;
        end else if (fifo_valid_i) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (flush_i) begin
          state_d = StFlush;
        end else if (tx_ready_i) begin
          state_d = go ? StRead : StIdle;
        end
      end
      StFlush: begin
        // ren_q low means no read response can still be in flight.
        if (!flush_i && fifo_empty_i && !ren_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    fifo_ren_o = (state_q == StRead) || ((state_q == StFlush) && !fifo_empty_i);
    tx_valid_o = (state_q == StPresent);
    busy_o     = (state_q != StIdle);
  end

  // Pending-done tracking: set by an accepted word, cleared by flush or by the done pulse.
  always_comb begin
    sent_pend_d = sent_pend_q;
    if (state_q == StFlush) begin
      sent_pend_d = 1'b0;
    end else if (handshake) begin
      sent_pend_d = 1'b1;
    end else if (done_cond) begin
      sent_pend_d = 1'b0;
    end
  end

  // State, hold register and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      sent_pend_q  <= 1'b0;
      ren_q        <= 1'b0;
      irq_thresh_q <= 1'b0;
      irq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sent_pend_q  <= sent_pend_d;
      ren_q        <= fifo_ren_o;
      irq_thresh_q <= en_i && (fifo_lvl_i <= thresh_i);
      irq_done_q   <= done_cond;
      if (hold_load) begin
        hold_q <= fifo_rdata_i;
      end
    end
  end

  assign tx_data_o    = hold_q;
  assign irq_thresh_o = irq_thresh_q;
  assign irq_done_o   = irq_done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural FIFO and serialiser around the DUT,
// expected words kept as plain arrays of what was loaded.
module tb_uart_tx_sched;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       en_i = 1'b0;
  logic       cts_en_i = 1'b0;
  logic       cts_n_i = 1'b1;
  logic       flush_i = 1'b0;
  logic [4:0] thresh_i = '0;
  logic       fifo_ren_o;
  logic [7:0] fifo_rdata_i = '0;
  logic       fifo_valid_i = 1'b0;
  logic       fifo_empty_i;
  logic [4:0] fifo_lvl_i = '0;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b0;
  logic       tx_busy_i = 1'b0;
  logic       irq_thresh_o;
  logic       irq_done_o;
  logic       busy_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  uart_tx_sched #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .cts_en_i    (cts_en_i),
    .cts_n_i     (cts_n_i),
    .flush_i     (flush_i),
    .thresh_i    (thresh_i),
    .fifo_ren_o  (fifo_ren_o),
    .fifo_rdata_i(fifo_rdata_i),
    .fifo_valid_i(fifo_valid_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_lvl_i  (fifo_lvl_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .tx_busy_i   (tx_busy_i),
    .irq_thresh_o(irq_thresh_o),
    .irq_done_o  (irq_done_o),
    .busy_o      (busy_o)
  );

  // FIFO model: one preloaded word enters per edge; ren pops with a 1-cycle valid.
  logic [7:0] fifo_q[$];
  logic [7:0] load_mem[0:255];
  int load_wr = 0;
  int load_rd = 0;

  assign fifo_empty_i = (fifo_lvl_i == 5'd0);

  always @(posedge clk_i) begin
    if (load_rd != load_wr) begin
      fifo_q.push_back(load_mem[load_rd[7:0]]);
      load_rd <= load_rd + 1;
    end
    if (fifo_ren_o && fifo_q.size() != 0) begin
      fifo_rdata_i <= fifo_q.pop_front();
      fifo_valid_i <= 1'b1;
    end else begin
      fifo_valid_i <= 1'b0;
    end
    fifo_lvl_i <= 5'(fifo_q.size());
  end

  // Monitor: counts events and records accepted words.
  int cyc = 0, ren_cnt = 0, hs_cnt = 0, done_cnt = 0, proto_err = 0;
  logic [7:0] hs_mem[0:255];
  int hs_cyc[0:255];
  logic pv = 1'b0, pr = 1'b0, pf = 1'b0, prst = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (fifo_ren_o) ren_cnt <= ren_cnt + 1;
    if (irq_done_o) done_cnt <= done_cnt + 1;
    if (tx_valid_o && tx_ready_i) begin
      hs_mem[hs_cnt[7:0]] <= tx_data_o;
      hs_cyc[hs_cnt[7:0]] <= cyc;
      hs_cnt <= hs_cnt + 1;
    end
    // An offered, unaccepted word must stay offered and unchanged unless flushed or reset.
    if (pv && !pr && !pf && prst && (!tx_valid_o || tx_data_o != pd)) proto_err <= proto_err + 1;
    pv   <= tx_valid_o;
    pr   <= tx_ready_i;
    pf   <= flush_i;
    prst <= reset_i;
    pd   <= tx_data_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    load_mem[load_wr[7:0]] = w;
    load_wr = load_wr + 1;
  endtask

  task automatic wait_loaded();
    for (int i = 0; i < 40; i++) begin
      if (load_rd == load_wr) break;
      step();
    end
    vectors++;
    if (load_rd != load_wr) begin
      miscompares++;
      $display("FAIL load_drain: got %0d pending, expected 0", load_wr - load_rd);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12; i++) begin
      if (tx_valid_o) break;
      step();
    end
    vectors++;
    if (tx_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: got tx_valid_o=%b, expected 1 within budget", name, tx_valid_o);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy_o && fifo_empty_i && load_rd == load_wr) break;
      step();
    end
    vectors++;
    if (busy_o || !fifo_empty_i) begin
      miscompares++;
      $display("FAIL %s: got busy_o=%b lvl=%0d, expected idle and empty", name, busy_o,
               fifo_lvl_i);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    step();
    step();
    vectors++;
    if ({tx_valid_o, fifo_ren_o, irq_thresh_o, irq_done_o, busy_o} !== 5'b0 ||
        tx_data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_init: got v=%b r=%b it=%b id=%b b=%b d=%h, expected all 0",
               tx_valid_o, fifo_ren_o, irq_thresh_o, irq_done_o, busy_o, tx_data_o);
    end
    reset_i = 1'b1;
    load_word(8'h5A);
    wait_loaded();
    en_i = 1'b1;
    wait_valid("reset_present");
    vectors++;
    if (tx_data_o !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_present_data: got %h, expected 5a", tx_data_o);
    end
    begin
      int d0;
      d0 = done_cnt;
      reset_i = 1'b0;
      en_i = 1'b0;
      step();
      reset_i = 1'b1;
      vectors++;
      if ({tx_valid_o, fifo_ren_o, irq_thresh_o, irq_done_o, busy_o} !== 5'b0 ||
          tx_data_o !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_mid_present: got v=%b r=%b it=%b id=%b b=%b d=%h, expected 0",
                 tx_valid_o, fifo_ren_o, irq_thresh_o, irq_done_o, busy_o, tx_data_o);
      end
      for (int i = 0; i < 5; i++) step();
      vectors++;
      if (done_cnt != d0) begin
        miscompares++;
        $display("FAIL reset_no_done: got %0d pulses, expected 0", done_cnt - d0);
      end
    end
  endtask

  task automatic test_single(input logic [7:0] w);
    bit found;
    found = 1'b0;
    en_i = 1'b0;
    tx_ready_i = 1'b0;
    tx_busy_i = 1'b0;
    load_word(w);
    wait_loaded();
    en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifo_ren_o) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL single_ren: got no ren pulse, expected one");
    end
    step();
    vectors++;
    if (fifo_ren_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wait: got ren=%b valid=%b, expected 0 0", fifo_ren_o, tx_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== w) begin
        miscompares++;
        $display("FAIL single_present[%0d]: got valid=%b data=%h, expected 1 %h", i,
                 tx_valid_o, tx_data_o, w);
      end
    end
    tx_ready_i = 1'b1;
    tx_busy_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    vectors++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got valid=%b busy=%b, expected 0 0", tx_valid_o, busy_o);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (irq_done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL single_done_early[%0d]: got %b, expected 0", i, irq_done_o);
      end
    end
    tx_busy_i = 1'b0;
    step();
    vectors++;
    if (irq_done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done: got %b, expected 1", irq_done_o);
    end
    step();
    vectors++;
    if (irq_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: got %b, expected 0", irq_done_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[3];
    int r0, h0, d0;
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w[k] = 8'($urandom);
      load_word(w[k]);
    end
    wait_loaded();
    r0 = ren_cnt;
    h0 = hs_cnt;
    d0 = done_cnt;
    tx_ready_i = 1'b1;
    en_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hs_cnt - h0 >= 3 && !busy_o) break;
    end
    for (int i = 0; i < 3; i++) step();
    tx_ready_i = 1'b0;
    vectors++;
    if (ren_cnt - r0 != 3) begin
      miscompares++;
      $display("FAIL b2b_ren: got %0d, expected 3", ren_cnt - r0);
    end
    vectors++;
    if (hs_cnt - h0 != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d, expected 3", hs_cnt - h0);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (hs_mem[8'(h0 + k)] !== w[k]) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %h, expected %h", k, hs_mem[8'(h0 + k)], w[k]);
      end
    end
    for (int k = 1; k < 3; k++) begin
      vectors++;
      if (hs_cyc[8'(h0 + k)] - hs_cyc[8'(h0 + k - 1)] != 3) begin
        miscompares++;
        $display("FAIL b2b_rate[%0d]: got %0d cycles, expected 3", k,
                 hs_cyc[8'(h0 + k)] - hs_cyc[8'(h0 + k - 1)]);
      end
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d pulses, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_cts();
    logic [7:0] w[4];
    int r0, h0, d0;
    en_i = 1'b0;
    cts_en_i = 1'b1;
    cts_n_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w[k] = 8'($urandom);
      load_word(w[k]);
    end
    wait_loaded();
    r0 = ren_cnt;
    h0 = hs_cnt;
    d0 = done_cnt;
    en_i = 1'b1;
    tx_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if (ren_cnt != r0) begin
      miscompares++;
      $display("FAIL cts_block: got %0d reads, expected 0", ren_cnt - r0);
    end
    cts_n_i = 1'b0;
    wait_valid("cts_start");
    cts_n_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    vectors++;
    if (ren_cnt - r0 != 1 || hs_cnt - h0 != 1) begin
      miscompares++;
      $display("FAIL cts_stop: got ren=%0d hs=%0d, expected 1 1", ren_cnt - r0, hs_cnt - h0);
    end
    vectors++;
    if (hs_mem[8'(h0)] !== w[0] || fifo_lvl_i !== 5'd3 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL cts_park: got data=%h lvl=%0d busy=%b, expected %h 3 0", hs_mem[8'(h0)],
               fifo_lvl_i, busy_o, w[0]);
    end
    cts_n_i = 1'b0;
    wait_idle("cts_drain");
    for (int i = 0; i < 3; i++) step();
    for (int k = 1; k < 4; k++) begin
      vectors++;
      if (hs_mem[8'(h0 + k)] !== w[k]) begin
        miscompares++;
        $display("FAIL cts_data[%0d]: got %h, expected %h", k, hs_mem[8'(h0 + k)], w[k]);
      end
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL cts_done: got %0d pulses, expected 1", done_cnt - d0);
    end
    tx_ready_i = 1'b0;
    cts_en_i = 1'b0;
    cts_n_i = 1'b1;
  endtask

  task automatic test_flush();
    logic [7:0] w[7];
    int h0, d0, n;
    en_i = 1'b0;
    tx_ready_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      w[k] = 8'($urandom);
      load_word(w[k]);
    end
    wait_loaded();
    h0 = hs_cnt;
    d0 = done_cnt;
    en_i = 1'b1;
    wait_valid("flush_first");
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    wait_valid("flush_second");
    vectors++;
    if (tx_data_o !== w[1] || fifo_lvl_i !== 5'd5) begin
      miscompares++;
      $display("FAIL flush_setup: got data=%h lvl=%0d, expected %h 5", tx_data_o, fifo_lvl_i,
               w[1]);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    vectors++;
    if (tx_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_retract: got valid=%b, expected 0", tx_valid_o);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!fifo_ren_o) break;
      n++;
      step();
    end
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL flush_reads: got %0d consecutive, expected 5", n);
    end
    wait_idle("flush_idle");
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (done_cnt != d0 || hs_cnt - h0 != 1) begin
      miscompares++;
      $display("FAIL flush_done: got done=%0d hs=%0d, expected 0 1", done_cnt - d0,
               hs_cnt - h0);
    end
  endtask

  task automatic test_thresh();
    logic e, exp_irq;
    logic [4:0] l, t;
    en_i = 1'b0;
    tx_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) load_word(8'($urandom));
    for (int i = 0; i < 32; i++) begin
      en_i = (i != 14 && i != 15);
      if (i < 18) thresh_i = 5'd2;
      else if (i < 24) thresh_i = 5'(DEPTH);
      else thresh_i = 5'($urandom_range(0, 31));
      tx_ready_i = (i >= 24);
      e = en_i;
      l = fifo_lvl_i;
      t = thresh_i;
      step();
      exp_irq = e && (l <= t);
      vectors++;
      if (irq_thresh_o !== exp_irq) begin
        miscompares++;
        $display("FAIL thresh[%0d]: got %b, expected %b (en=%b lvl=%0d th=%0d)", i,
                 irq_thresh_o, exp_irq, e, l, t);
      end
    end
    wait_idle("thresh_drain");
    tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_protocol();
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("FAIL valid_stable: got %0d retractions/changes, expected 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_back_to_back();
    test_back_to_back();
    test_cts();
    test_flush();
    test_thresh();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
